// File: rtl/ddma_ctrl.sv
// ddma_ctrl: CPU-facing control/status slave for the double DMA.
// Latches DMA IRQ edges into maskable pending bits and orders both handshakes.
module ddma_ctrl #(
    parameter int MEMORY_BUS_WIDTH   = 32,
    parameter int INTERLEAVING_GRAIN = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [5:0]                  bus_addr_in,
    input  logic [MEMORY_BUS_WIDTH-1:0] bus_data_in,
    input  logic                        bus_wr_in,
    input  logic                        bus_rd_in,
    output logic [MEMORY_BUS_WIDTH-1:0] bus_data_out,
    output logic                        bus_ready_out,
    output logic                        irq_out,
    output logic                        send_cmd_out,
    output logic [MEMORY_BUS_WIDTH-1:0] send_addr_out,
    output logic [MEMORY_BUS_WIDTH-1:0] send_size_out,
    output logic [MEMORY_BUS_WIDTH-1:0] send_dest_out,
    output logic [MEMORY_BUS_WIDTH-1:0] recv_cmd_out,
    output logic [MEMORY_BUS_WIDTH-1:0] recv_addr_out,
    input  logic                        irq_send_in,
    input  logic                        irq_recv_size_in,
    input  logic                        irq_recv_hshk_in,
    input  logic [MEMORY_BUS_WIDTH-1:0] recv_size_in,
    input  logic [MEMORY_BUS_WIDTH-1:0] state_send_in,
    input  logic [MEMORY_BUS_WIDTH-1:0] state_recv_in
);

    localparam int W = MEMORY_BUS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BUSY    = 3'd1,
        S_DONE    = 3'd2,
        S_RELEASE = 3'd3
    } send_st_e;

    typedef enum logic [2:0] {
        R_WAIT_SIZE = 3'd0,
        R_SIZE      = 3'd1,
        R_DATA      = 3'd2,
        R_HSHK      = 3'd3,
        R_CLEAR     = 3'd4
    } recv_st_e;

    localparam logic [3:0] A_SEND_ADDR = 4'd0;
    localparam logic [3:0] A_SEND_SIZE = 4'd1;
    localparam logic [3:0] A_SEND_DEST = 4'd2;
    localparam logic [3:0] A_CMD       = 4'd3;
    localparam logic [3:0] A_RECV_ADDR = 4'd4;
    localparam logic [3:0] A_RECV_SIZE = 4'd5;
    localparam logic [3:0] A_STATUS    = 4'd6;
    localparam logic [3:0] A_PENDING   = 4'd7;
    localparam logic [3:0] A_MASK      = 4'd8;
    localparam logic [3:0] A_GRAIN     = 4'd9;

    send_st_e     send_q;
    recv_st_e     recv_q;
    logic         send_cmd_q;
    logic         toggle_q;
    logic [W-1:0] send_addr_q;
    logic [W-1:0] send_size_q;
    logic [W-1:0] send_dest_q;
    logic [W-1:0] recv_addr_q;
    logic [W-1:0] recv_size_q;
    logic [W-1:0] grain_q;
    logic [2:0]   pend_q;
    logic [2:0]   pend_d;
    logic [2:0]   mask_q;
    logic         err_send_q;
    logic         err_send_d;
    logic         err_recv_q;
    logic         err_recv_d;
    logic         irq_send_q;
    logic         irq_rsize_q;
    logic         irq_rhshk_q;
    logic [W-1:0] rdata_d;
    logic [W-1:0] rdata_q;
    logic         ready_q;

    logic [3:0] idx;
    logic       wr;
    logic       rd;
    logic       cmd_wr;
    logic       pend_wr;
    logic       cmd_start;
    logic       cmd_sack;
    logic       cmd_rack;
    logic [2:0] edge_v;
    logic       send_err_set;
    logic       recv_err_set;
    logic       send_cfg_open;
    logic       recv_cfg_open;

    assign idx       = bus_addr_in[5:2];
    assign wr        = bus_wr_in;
    assign rd        = bus_rd_in & ~bus_wr_in;
    assign cmd_wr    = wr && (idx == A_CMD);
    assign pend_wr   = wr && (idx == A_PENDING);
    assign cmd_start = cmd_wr & bus_data_in[0];
    assign cmd_sack  = cmd_wr & bus_data_in[1];
    assign cmd_rack  = cmd_wr & bus_data_in[2];

    assign edge_v = {irq_recv_hshk_in & ~irq_rhshk_q,
                     irq_recv_size_in & ~irq_rsize_q,
                     irq_send_in      & ~irq_send_q};

    assign send_err_set = (cmd_start && send_q != S_IDLE) ||
                          (cmd_sack  && send_q != S_DONE);
    assign recv_err_set = cmd_rack && !(recv_q == R_SIZE || recv_q == R_HSHK);

    assign send_cfg_open = (send_q == S_IDLE);
    assign recv_cfg_open = !(recv_q == R_DATA || recv_q == R_HSHK);

    // Edge sets are applied after the w1c mask so a coincident set wins.
    always_comb begin
        pend_d     = pend_q;
        err_send_d = err_send_q;
        err_recv_d = err_recv_q;
        if (pend_wr) begin
            pend_d = pend_q & ~bus_data_in[2:0];
            if (bus_data_in[3]) err_send_d = 1'b0;
            if (bus_data_in[4]) err_recv_d = 1'b0;
        end
        pend_d = pend_d | edge_v;
        if (send_err_set) err_send_d = 1'b1;
        if (recv_err_set) err_recv_d = 1'b1;
    end

    always_comb begin
        rdata_d = '0;
        case (idx)
            A_SEND_ADDR: rdata_d = send_addr_q;
            A_SEND_SIZE: rdata_d = send_size_q;
            A_SEND_DEST: rdata_d = send_dest_q;
            A_RECV_ADDR: rdata_d = recv_addr_q;
            A_RECV_SIZE: rdata_d = recv_size_q;
            A_STATUS: begin
                rdata_d[2:0]   = send_q;
                rdata_d[6:4]   = recv_q;
                rdata_d[8]     = err_send_q;
                rdata_d[9]     = err_recv_q;
                rdata_d[18:16] = state_send_in[2:0];
                rdata_d[22:20] = state_recv_in[2:0];
            end
            A_PENDING:   rdata_d[2:0] = pend_q;
            A_MASK:      rdata_d[2:0] = mask_q;
            A_GRAIN:     rdata_d = grain_q;
            default:     rdata_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= bus_rd_in | bus_wr_in;
            if (rd) rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            send_addr_q <= '0;
            send_size_q <= '0;
            send_dest_q <= '0;
            recv_addr_q <= '0;
            mask_q      <= '0;
            grain_q     <= W'(INTERLEAVING_GRAIN);
        end else begin
            if (wr && send_cfg_open && idx == A_SEND_ADDR) send_addr_q <= bus_data_in;
            if (wr && send_cfg_open && idx == A_SEND_SIZE) send_size_q <= bus_data_in;
            if (wr && send_cfg_open && idx == A_SEND_DEST) send_dest_q <= bus_data_in;
            if (wr && recv_cfg_open && idx == A_RECV_ADDR) recv_addr_q <= bus_data_in;
            if (wr && idx == A_MASK) mask_q <= bus_data_in[2:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq_send_q  <= 1'b0;
            irq_rsize_q <= 1'b0;
            irq_rhshk_q <= 1'b0;
            pend_q      <= '0;
            err_send_q  <= 1'b0;
            err_recv_q  <= 1'b0;
        end else begin
            irq_send_q  <= irq_send_in;
            irq_rsize_q <= irq_recv_size_in;
            irq_rhshk_q <= irq_recv_hshk_in;
            pend_q      <= pend_d;
            err_send_q  <= err_send_d;
            err_recv_q  <= err_recv_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            send_q     <= S_IDLE;
            send_cmd_q <= 1'b0;
        end else begin
            case (send_q)
                S_IDLE: if (cmd_start) begin
                    send_cmd_q <= 1'b1;
                    send_q     <= S_BUSY;
                end
                S_BUSY: if (edge_v[0]) send_q <= S_DONE;
                S_DONE: if (cmd_sack) begin
                    send_cmd_q <= 1'b0;
                    send_q     <= S_RELEASE;
                end
                S_RELEASE: if (!irq_send_in) send_q <= S_IDLE;
                default: begin
                    send_cmd_q <= 1'b0;
                    send_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Each toggle needs a fresh DMA edge first, so it stays stable for many cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            recv_q      <= R_WAIT_SIZE;
            toggle_q    <= 1'b0;
            recv_size_q <= '0;
        end else begin
            case (recv_q)
                R_WAIT_SIZE: if (edge_v[1]) begin
                    recv_size_q <= recv_size_in;
                    recv_q      <= R_SIZE;
                end
                R_SIZE: if (cmd_rack) begin
                    toggle_q <= ~toggle_q;
                    recv_q   <= R_DATA;
                end
                R_DATA: if (edge_v[2]) recv_q <= R_HSHK;
                R_HSHK: if (cmd_rack) begin
                    toggle_q <= ~toggle_q;
                    recv_q   <= R_CLEAR;
                end
                R_CLEAR: if (!irq_recv_hshk_in) recv_q <= R_WAIT_SIZE;
                default: recv_q <= R_WAIT_SIZE;
            endcase
        end
    end

    assign bus_data_out  = rdata_q;
    assign bus_ready_out = ready_q;
    assign irq_out       = |(pend_q & mask_q);
    assign send_cmd_out  = send_cmd_q;
    assign send_addr_out = send_addr_q;
    assign send_size_out = send_size_q;
    assign send_dest_out = send_dest_q;
    assign recv_addr_out = recv_addr_q;
    assign recv_cmd_out  = {{(W-1){1'b0}}, toggle_q};

    logic unused_bits;
    assign unused_bits = ^{bus_addr_in[1:0], state_send_in[W-1:3], state_recv_in[W-1:3]};

endmodule

// File: tb/tb_ddma_ctrl.sv
// tb_ddma_ctrl: directed handshake sequence plus randomized register traffic
// checked against a flat register/pending model.
module tb_ddma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  bus_addr = '0;
    logic [31:0] bus_data = '0;
    logic        bus_wr = 1'b0;
    logic        bus_rd = 1'b0;
    logic [31:0] data_out;
    logic        ready;
    logic        irq;
    logic        send_cmd;
    logic [31:0] send_addr;
    logic [31:0] send_size;
    logic [31:0] send_dest;
    logic [31:0] recv_cmd;
    logic [31:0] recv_addr;
    logic        irq_send = 1'b0;
    logic        irq_rsize = 1'b0;
    logic        irq_rhshk = 1'b0;
    logic [31:0] recv_size = '0;
    logic [31:0] st_send = '0;
    logic [31:0] st_recv = '0;

    int tests = 0;
    int fails = 0;

    ddma_ctrl #(.MEMORY_BUS_WIDTH(32), .INTERLEAVING_GRAIN(3)) dut (
        .clock           (clk),
        .reset           (rst_n),
        .bus_addr_in     (bus_addr),
        .bus_data_in     (bus_data),
        .bus_wr_in       (bus_wr),
        .bus_rd_in       (bus_rd),
        .bus_data_out    (data_out),
        .bus_ready_out   (ready),
        .irq_out         (irq),
        .send_cmd_out    (send_cmd),
        .send_addr_out   (send_addr),
        .send_size_out   (send_size),
        .send_dest_out   (send_dest),
        .recv_cmd_out    (recv_cmd),
        .recv_addr_out   (recv_addr),
        .irq_send_in     (irq_send),
        .irq_recv_size_in(irq_rsize),
        .irq_recv_hshk_in(irq_rhshk),
        .recv_size_in    (recv_size),
        .state_send_in   (st_send),
        .state_recv_in   (st_recv)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] i, input logic [31:0] d);
        bus_addr = {i, 2'b00};
        bus_data = d;
        bus_wr = 1'b1;
        tick();
        bus_wr = 1'b0;
        chk("wr_ready", {31'b0, ready}, 32'd1);
    endtask

    task automatic rd(input logic [3:0] i, output logic [31:0] d);
        bus_addr = {i, 2'b00};
        bus_rd = 1'b1;
        tick();
        bus_rd = 1'b0;
        chk("rd_ready", {31'b0, ready}, 32'd1);
        d = data_out;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] m [16];
        logic [2:0]  pend;
        logic        pi;
        int          wl [10];
        int          rl [9];

        wl = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 12};
        rl = '{0, 1, 2, 4, 5, 7, 8, 9, 13};

        // reset state
        repeat (3) tick();
        chk("rst_send_cmd", {31'b0, send_cmd}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_recv_cmd", recv_cmd, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        rst_n = 1'b1;
        tick();

        wr(4'd0, 32'h100);
        chk("pre_rst_addr", send_addr, 32'h100);
        tick();
        chk("ready_pulse", {31'b0, ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_addr", send_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        rd(4'd0, v);
        chk("rd_send_addr_rst", v, 32'd0);
        rd(4'd9, v);
        chk("grain", v, 32'd3);
        wr(4'd0, 32'h200);
        chk("rd_data_hold", data_out, 32'd3);

        // send handshake
        st_send = 32'h5;
        st_recv = 32'h6;
        wr(4'd1, 32'd4);
        wr(4'd2, 32'h11);
        wr(4'd3, 32'd1);
        chk("send_cmd_on", {31'b0, send_cmd}, 32'd1);
        chk("send_addr", send_addr, 32'h200);
        chk("send_dest", send_dest, 32'h11);
        rd(4'd6, v);
        chk("st_busy", {29'b0, v[2:0]}, 32'd1);
        chk("st_dma_send", {29'b0, v[18:16]}, 32'd5);
        chk("st_dma_recv", {29'b0, v[22:20]}, 32'd6);
        wr(4'd1, 32'd9);
        rd(4'd1, v);
        chk("cfg_lock", v, 32'd4);
        wr(4'd3, 32'd1);
        rd(4'd6, v);
        chk("err_send_set", {31'b0, v[8]}, 32'd1);
        wr(4'd7, 32'h8);
        rd(4'd6, v);
        chk("err_send_clr", {31'b0, v[8]}, 32'd0);
        wr(4'd8, 32'd1);
        chk("irq_pre", {31'b0, irq}, 32'd0);
        irq_send = 1'b1;
        tick();
        chk("irq_send_out", {31'b0, irq}, 32'd1);
        rd(4'd7, v);
        chk("pend_send", v, 32'd1);
        rd(4'd6, v);
        chk("st_done", {29'b0, v[2:0]}, 32'd2);
        wr(4'd3, 32'd2);
        chk("send_cmd_off", {31'b0, send_cmd}, 32'd0);
        rd(4'd6, v);
        chk("st_release", {29'b0, v[2:0]}, 32'd3);
        irq_send = 1'b0;
        tick();
        rd(4'd6, v);
        chk("st_idle", {29'b0, v[2:0]}, 32'd0);
        wr(4'd7, 32'd1);
        chk("irq_cleared", {31'b0, irq}, 32'd0);

        // w1c racing a new edge
        bus_addr = {4'd7, 2'b00};
        bus_data = 32'd1;
        bus_wr = 1'b1;
        irq_send = 1'b1;
        tick();
        bus_wr = 1'b0;
        irq_send = 1'b0;
        rd(4'd7, v);
        chk("race_set_wins", v, 32'd1);
        wr(4'd7, 32'd1);
        rd(4'd7, v);
        chk("pend_clr", v, 32'd0);

        // receive handshake
        wr(4'd4, 32'h400);
        chk("recv_addr", recv_addr, 32'h400);
        wr(4'd3, 32'd4);
        chk("ooo_toggle", recv_cmd, 32'd0);
        rd(4'd6, v);
        chk("err_recv_set", {31'b0, v[9]}, 32'd1);
        wr(4'd7, 32'h10);
        rd(4'd6, v);
        chk("err_recv_clr", {31'b0, v[9]}, 32'd0);
        recv_size = 32'd5;
        irq_rsize = 1'b1;
        tick();
        rd(4'd5, v);
        chk("recv_size", v, 32'd5);
        rd(4'd7, v);
        chk("pend_rsize", v, 32'd2);
        rd(4'd6, v);
        chk("st_r_size", {29'b0, v[6:4]}, 32'd1);
        wr(4'd3, 32'd4);
        chk("toggle_1", recv_cmd, 32'd1);
        tick();
        chk("toggle_1_hold", recv_cmd, 32'd1);
        wr(4'd4, 32'h999);
        rd(4'd4, v);
        chk("recv_addr_lock", v, 32'h400);
        irq_rhshk = 1'b1;
        tick();
        rd(4'd7, v);
        chk("pend_rhshk", v, 32'd6);
        rd(4'd6, v);
        chk("st_r_hshk", {29'b0, v[6:4]}, 32'd3);
        wr(4'd3, 32'd4);
        chk("toggle_0", recv_cmd, 32'd0);
        rd(4'd6, v);
        chk("st_r_clear", {29'b0, v[6:4]}, 32'd4);
        irq_rhshk = 1'b0;
        irq_rsize = 1'b0;
        tick();
        rd(4'd6, v);
        chk("st_r_wait", {29'b0, v[6:4]}, 32'd0);

        // all three CMD bits in one write, then reset mid-operation
        wr(4'd3, 32'd7);
        chk("multi_start", {31'b0, send_cmd}, 32'd1);
        rd(4'd6, v);
        chk("multi_errs", {30'b0, v[9:8]}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("midop_send_cmd", {31'b0, send_cmd}, 32'd0);
        chk("midop_recv_addr", recv_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // randomized register traffic against a flat model
        for (int i = 0; i < 16; i++) m[i] = '0;
        m[9] = 32'd3;
        pend = '0;
        pi = 1'b0;
        for (int k = 0; k < 40; k++) begin
            logic [3:0]  wi;
            logic [3:0]  ri;
            logic [31:0] d;
            logic        ni;
            logic        e;
            wi = 4'(wl[$urandom_range(0, 9)]);
            d = $urandom;
            ni = 1'($urandom_range(0, 1));
            e = ni & ~pi;
            pi = ni;
            irq_send = ni;
            wr(wi, d);
            if (wi == 4'd0 || wi == 4'd1 || wi == 4'd2 || wi == 4'd4) m[wi] = d;
            else if (wi == 4'd8) m[8] = {29'b0, d[2:0]};
            if (wi == 4'd7) pend = pend & ~d[2:0];
            pend = pend | {2'b0, e};
            chk("rnd_irq", {31'b0, irq}, {31'b0, |(pend & m[8][2:0])});
            chk("rnd_send_size", send_size, m[1]);
            ri = 4'(rl[$urandom_range(0, 8)]);
            rd(ri, v);
            chk("rnd_rd", v, (ri == 4'd7) ? {29'b0, pend} : m[ri]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ddma_ctrl.md
Name: ddma_ctrl

Overview:
- CPU-facing memory-mapped control/status slave sitting directly upstream of the double DMA.
- Drives the DMA command interface: send address/size/destination, level send command, toggle receive command, receive buffer address.
- Converts the DMA's level-held IRQ outputs into rising-edge-latched, maskable pending bits.
- Sequences both handshakes so the CPU can never issue an out-of-order ack.

Parameters:
MEMORY_BUS_WIDTH, 32, width of CPU data bus and all DMA address/size/data words
INTERLEAVING_GRAIN, 3, reset value of the GRAIN shadow register (read-only copy exported for software)

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-low reset (reset==0 resets all state immediately)
bus_addr_in  in  6  byte address; bits [5:2] select the register, bits [1:0] ignored
bus_data_in  in  MEMORY_BUS_WIDTH  write data
bus_wr_in  in  1  write strobe, one cycle
bus_rd_in  in  1  read strobe, one cycle
bus_data_out  out  MEMORY_BUS_WIDTH  read data, registered
bus_ready_out  out  1  one-cycle pulse, one cycle after a strobe
irq_out  out  1  OR of (pending & mask)
send_cmd_out  out  1  level send command to DMA
send_addr_out / send_size_out / send_dest_out  out  MEMORY_BUS_WIDTH each  send config
recv_cmd_out  out  MEMORY_BUS_WIDTH  receive command; bit0 toggles, other bits 0
recv_addr_out  out  MEMORY_BUS_WIDTH  receive buffer base
irq_send_in, irq_recv_size_in, irq_recv_hshk_in  in  1 each  DMA level IRQs
recv_size_in  in  MEMORY_BUS_WIDTH  flit count from DMA
state_send_in, state_recv_in  in  MEMORY_BUS_WIDTH each  DMA FSM states

Behaviour:
- Register map (word index): 0 SEND_ADDR rw; 1 SEND_SIZE rw; 2 SEND_DEST rw; 3 CMD wo; 4 RECV_ADDR rw; 5 RECV_SIZE ro; 6 STATUS ro; 7 PENDING w1c; 8 MASK rw[2:0]; 9 GRAIN ro.
- Unmapped reads return 0; unmapped or ro writes are ignored.
- CMD bits: bit0 START, bit1 SEND_ACK, bit2 RECV_ACK. Multiple bits in one write are processed independently in the same cycle.
- Reset: all registers 0 except GRAIN=INTERLEAVING_GRAIN; all outputs 0; both FSMs at their first state; edge-detect flops 0.
- Bus: a strobe in cycle N gives bus_ready_out=1 in N+1. Read data is valid in N+1 and holds until the next read. Write effects are visible from N+1. rd and wr together are treated as a write.
- IRQ edges: each irq_*_in is registered. A 0->1 transition sets PENDING[0]=send, [1]=recv_size, [2]=recv_hshk.
  - A w1c clear and an edge on the same bit in the same cycle: the set wins.
  - irq_out is combinational from the pending/mask registers.
- Send FSM (S_IDLE, S_BUSY, S_DONE, S_RELEASE):
  - S_IDLE: START -> send_cmd_out=1, go to S_BUSY.
  - S_BUSY: irq_send_in edge -> S_DONE.
  - S_DONE: SEND_ACK -> send_cmd_out=0, go to S_RELEASE.
  - S_RELEASE: irq_send_in==0 -> S_IDLE.
  - SEND_ADDR/SIZE/DEST writes are ignored outside S_IDLE (config locked).
  - START outside S_IDLE, or SEND_ACK outside S_DONE: ignored, sets STATUS.err_send (sticky, cleared by writing PENDING bit3).
- Recv FSM (R_WAIT_SIZE, R_SIZE, R_DATA, R_HSHK, R_CLEAR):
  - R_WAIT_SIZE: irq_recv_size_in edge -> capture recv_size_in into RECV_SIZE, go to R_SIZE.
  - R_SIZE: RECV_ACK -> toggle recv_cmd_out bit0, go to R_DATA.
  - R_DATA: irq_recv_hshk_in edge -> R_HSHK.
  - R_HSHK: RECV_ACK -> toggle, go to R_CLEAR.
  - R_CLEAR: irq_recv_hshk_in==0 -> R_WAIT_SIZE.
  - RECV_ACK in any other state: ignored, sets sticky STATUS.err_recv (cleared by writing PENDING bit4).
  - RECV_ADDR writes are ignored in R_DATA and R_HSHK.
  - Toggle guarantee: recv_cmd_out changes at most once per ack and holds stable for at least 2 cycles (the DMA compares against a one-cycle-delayed copy).
- STATUS layout: [2:0] send FSM, [6:4] recv FSM, [8] err_send, [9] err_recv, [18:16] state_send_in[2:0], [22:20] state_recv_in[2:0].
- Reset mid-operation: all outputs drop to 0 asynchronously, including send_cmd_out and the recv toggle. Software must re-arm.

Test Plan:
- Reset: write SEND_ADDR=0x100, then pulse reset low -> all outputs 0, read SEND_ADDR=0, read GRAIN=3.
- Send: write ADDR=0x200, SIZE=4, DEST=0x11, CMD=1 -> send_cmd_out=1 the next cycle. Raise irq_send_in -> PENDING=1; with MASK=1, irq_out=1. CMD=2 -> send_cmd_out=0. Drop irq_send_in -> STATUS[2:0]=S_IDLE.
- Config lock: in S_BUSY, write SEND_SIZE=9 -> read SEND_SIZE=4. Write CMD=1 -> STATUS[8]=1. Write PENDING bit3 -> STATUS[8]=0.
- Recv: RECV_ADDR=0x400; irq_recv_size_in rises with recv_size_in=5 -> RECV_SIZE=5, PENDING[1]=1. CMD=4 -> recv_cmd_out bit0 0->1. irq_recv_hshk_in rises -> PENDING[2]. CMD=4 -> bit0 1->0.
- Out-of-order: CMD=4 in R_WAIT_SIZE -> recv_cmd_out unchanged, STATUS[9]=1.
- Clear/set race: write PENDING=1 in the same cycle as a new irq_send_in edge -> PENDING[0] stays 1.
